immgen: RTL and testbench

// - Immediate generator for the RV32I decode stage, with the team's FLW/FSW float load/store extension.
// - Extracts and sign-extends the immediate field of a 32-bit instruction word.
// - Feeds the ALU operand-B mux and the branch/jump target adder.
// - Combinational by default; an optional output register is available via CONFIGURATION.
//

---
 rtl/immgen_pkg.sv | 43 ++++
 rtl/immgen_fmt_dec.sv | 27 ++
 rtl/immgen.sv | 59 +++++
 tb/tb_immgen.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/immgen_pkg.sv
// Shared opcode constants, immediate format enum and sign-extension helpers
// for the RV32I (+FLW/FSW) immediate generator.
package immgen_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FLW    = 7'b0000111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_FSW    = 7'b0100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        I    = 3'd1,
        S    = 3'd2,
        B    = 3'd3,
        U    = 3'd4,
        J    = 3'd5
    } imm_fmt_t;

    function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
        return {{(XLEN-12){v[11]}}, v};
    endfunction

    // Branch/jump offsets are even; bit 0 is implied and not encoded.
    function automatic logic [XLEN-1:0] sext13(input logic [12:0] v);
        return {{(XLEN-13){v[12]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] sext21(input logic [20:0] v);
        return {{(XLEN-21){v[20]}}, v};
    endfunction

endpackage

// File: rtl/immgen_fmt_dec.sv
// Opcode to immediate-format decoder. funct3/funct7 are deliberately ignored;
// anything without an immediate (OP, OP-FP, SYSTEM, undefined) maps to NONE.
module immgen_fmt_dec
    import immgen_pkg::*;
(
    input  logic [6:0] opcode,
    output imm_fmt_t   fmt
);

    always_comb begin
        fmt = NONE;
        case (opcode)
            OPC_LOAD,
            OPC_FLW,
            OPC_OP_IMM,
            OPC_JALR:   fmt = I;
            OPC_STORE,
            OPC_FSW:    fmt = S;
            OPC_BRANCH: fmt = B;
            OPC_LUI,
            OPC_AUIPC:  fmt = U;
            OPC_JAL:    fmt = J;
            default:    fmt = NONE;
        endcase
    end

endmodule

// File: rtl/immgen.sv
// Immediate generator for decode: format mux over the instruction fields.
// Define IMMGEN_REG_OUT_EN to register imm/fmt (1-cycle latency, async clear).
module immgen
    import immgen_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] instr,
    output logic [31:0] imm,
    output logic [2:0]  fmt
);

    imm_fmt_t           fmt_c;
    logic [XLEN-1:0]    imm_c;

    immgen_fmt_dec u_fmt_dec (
        .opcode (instr[6:0]),
        .fmt    (fmt_c)
    );

    // Shift-immediates take the raw 12-bit field, so SRAI keeps its 0x400 flag.
    always_comb begin
        imm_c = '0;
        case (fmt_c)
            I:       imm_c = sext12(instr[31:20]);
            S:       imm_c = sext12({instr[31:25], instr[11:7]});
            B:       imm_c = sext13({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
            U:       imm_c = {instr[31:12], 12'b0};
            J:       imm_c = sext21({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
            default: imm_c = '0;
        endcase
    end

`ifdef IMMGEN_REG_OUT_EN
    imm_fmt_t           fmt_q;
    logic [XLEN-1:0]    imm_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            imm_q <= '0;
            fmt_q <= NONE;
        end else begin
            imm_q <= imm_c;
            fmt_q <= fmt_c;
        end
    end

    assign imm = imm_q;
    assign fmt = fmt_q;
`else
    // Clock and reset only feed the optional output register.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rstn;

    assign imm = imm_c;
    assign fmt = fmt_c;
`endif

endmodule

// File: tb/tb_immgen.sv
// Directed-vector bench for immgen; covers the combinational build and, with
// IMMGEN_REG_OUT_EN defined, the registered build.
module tb_immgen;

    logic        clk;
    logic        rstn;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  fmt;

    int n_vec;
    int n_bad;

    localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2,
                           F_B = 3'd3, F_U = 3'd4, F_J = 3'd5;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  fmt;
    } vec_t;

    vec_t vecs[16];

    immgen dut (
        .clk   (clk),
        .rstn  (rstn),
        .instr (instr),
        .imm   (imm),
        .fmt   (fmt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] exp_imm,
                         input logic [2:0] exp_fmt);
        n_vec++;
        if ($isunknown({imm, fmt}) || imm !== exp_imm || fmt !== exp_fmt) begin
            n_bad++;
            $display("FAIL %s: got imm=%08h fmt=%0d, want imm=%08h fmt=%0d",
                     name, imm, fmt, exp_imm, exp_fmt);
        end
    endtask

    // Drive on the falling edge; sample after the outputs are due.
    task automatic apply(input logic [31:0] v);
        @(negedge clk);
        instr = v;
`ifdef IMMGEN_REG_OUT_EN
        @(negedge clk);
`else
        #1;
`endif
    endtask

    function automatic logic [2:0] ref_fmt(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0000111: return F_I;
            7'b0100011, 7'b0100111:                         return F_S;
            7'b1100011:                                     return F_B;
            7'b0110111, 7'b0010111:                         return F_U;
            7'b1101111:                                     return F_J;
            default:                                        return F_NONE;
        endcase
    endfunction

    initial begin
        logic [2:0]  ef;
        logic [31:0] ei;
        n_vec = 0;
        n_bad = 0;

        vecs[0]  = '{"addi_m1",   32'hFFF00093, 32'hFFFFFFFF, F_I};
        vecs[1]  = '{"sw_8",      32'h0020A423, 32'h00000008, F_S};
        vecs[2]  = '{"beq_m4",    32'hFE000EE3, 32'hFFFFFFFC, F_B};
        vecs[3]  = '{"lui",       32'h123450B7, 32'h12345000, F_U};
        vecs[4]  = '{"jal_2048",  32'h001000EF, 32'h00000800, F_J};
        vecs[5]  = '{"add",       32'h002081B3, 32'h00000000, F_NONE};
        vecs[6]  = '{"srai_3",    32'h4030D093, 32'h00000403, F_I};
        vecs[7]  = '{"flw_4",     32'h0040A087, 32'h00000004, F_I};
        vecs[8]  = '{"fsw_m8",    32'hFE20AC27, 32'hFFFFFFF8, F_S};
        vecs[9]  = '{"auipc_max", 32'hFFFFF097, 32'hFFFFF000, F_U};
        vecs[10] = '{"jalr_min",  32'h80000067, 32'hFFFFF800, F_I};
        vecs[11] = '{"jal_m4",    32'hFFDFF0EF, 32'hFFFFFFFC, F_J};
        vecs[12] = '{"lw_m1",     32'hFFF02083, 32'hFFFFFFFF, F_I};
        vecs[13] = '{"bge_max",   32'h7E000FE3, 32'h00000FFE, F_B};
        vecs[14] = '{"ecall",     32'h00000073, 32'h00000000, F_NONE};
        vecs[15] = '{"op_fp",     32'hFFFFFFD3, 32'h00000000, F_NONE};

        instr = 32'hFFF00093;
        rstn  = 1'b0;
        repeat (3) @(negedge clk);
`ifdef IMMGEN_REG_OUT_EN
        check("reset_clears", 32'h0, F_NONE);
        // First edge after release loads the decode of the instr already present.
        rstn = 1'b1;
        @(negedge clk);
        check("first_edge_load", 32'hFFFFFFFF, F_I);
        // Async clear mid-cycle, with no clock edge in between.
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("async_clear", 32'h0, F_NONE);
        instr = 32'h123450B7;
        @(negedge clk);
        check("held_in_reset", 32'h0, F_NONE);
        rstn = 1'b1;
        #1;
        check("no_edge_after_release", 32'h0, F_NONE);
        @(negedge clk);
        check("load_after_release", 32'h12345000, F_U);
`else
        check("reset_passthru", 32'hFFFFFFFF, F_I);
        // Output follows instr with no clock edge, whatever rstn is doing.
        @(posedge clk);
        #2;
        instr = 32'hFE000EE3;
        #1;
        check("mid_cycle_change", 32'hFFFFFFFC, F_B);
        rstn = 1'b1;
        #1;
        check("rstn_no_effect", 32'hFFFFFFFC, F_B);
`endif
        rstn = 1'b1;

        for (int k = 0; k < 16; k++) begin
            apply(vecs[k].instr);
            check(vecs[k].name, vecs[k].imm, vecs[k].fmt);
        end

        // Every opcode with all upper bits set: known outputs, right format.
        for (int op = 0; op < 128; op++) begin
            ef = ref_fmt(op[6:0]);
            case (ef)
                F_I, F_S:  ei = 32'hFFFFFFFF;
                F_B, F_J:  ei = 32'hFFFFFFFE;
                F_U:       ei = 32'hFFFFF000;
                default:   ei = 32'h0;
            endcase
            apply({25'h1FFFFFF, op[6:0]});
            check($sformatf("sweep_op_%02h", op), ei, ef);
        end

        // Back-to-back changes: each value tracks its own instr.
        apply(32'h001000EF);
        check("b2b_jal", 32'h00000800, F_J);
        apply(32'h002081B3);
        check("b2b_add", 32'h00000000, F_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
